// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Consumer-side controller for a synchronous FIFO. Issues
//                reads, captures the read data one cycle later and presents
//                it on a valid/ready stream through a 2-entry skid buffer.
//                Counts accepted words and flags captured underflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err,
    output logic                  idle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] C_BUF_DEPTH = 2'd2;

    state_t                  state_q, state_d;
    logic [1:0]              occ_q, occ_d;
    logic                    pending_q, pending_d;
    logic [FIFO_WIDTH-1:0]   head_q, head_d;
    logic [FIFO_WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_WIDTH-1:0]    rd_count_q, rd_count_d;
    logic                    underflow_err_q, underflow_err_d;

    logic                    w_pop;
    logic                    w_push;
    logic [1:0]              w_level;
    logic [1:0]              w_occ_after_pop;

    // Handshake and buffer-level bookkeeping; the level counts the in-flight
    // word so a slot is always reserved for it before a read is issued.
    assign w_pop           = m_valid & m_ready;
    assign w_level         = occ_q + {1'b0, pending_q};
    assign w_occ_after_pop = occ_q - {1'b0, w_pop};
    assign w_push          = pending_q & ~fifo_underflow & ~flush;

    // Read request: a pop in this cycle frees a slot for the word returning next cycle.
    assign fifo_rd_en = (state_q == ST_RUN) & ~fifo_empty & ~flush &
                        ((w_level < C_BUF_DEPTH) | w_pop);

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = head_q;
    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;
    assign idle          = (state_q == ST_IDLE);

    // Next-state logic for the run/drain controller.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) state_d = (w_level != 2'd0) ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (enable)                state_d = ST_RUN;
                    else if (w_level == 2'd0)  state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Skid buffer, counter and error flag next values; head shifts on pop,
    // new word lands in the first free slot after the pop.
    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        occ_d           = occ_q;
        pending_d       = fifo_rd_en;
        rd_count_d      = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, w_pop};
        underflow_err_d = underflow_err_q | (pending_q & fifo_underflow & ~flush);

        if (w_pop) begin
            head_d = tail_q;
        end
        if (w_push) begin
            if (w_occ_after_pop == 2'd0) head_d = fifo_data_out;
            else                         tail_d = fifo_data_out;
        end

        if (flush) occ_d = 2'd0;
        else       occ_d = w_occ_after_pop + {1'b0, w_push};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q           <= 2'd0;
            pending_q       <= 1'b0;
            head_q          <= '0;
            tail_q          <= '0;
            rd_count_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            occ_q           <= occ_d;
            pending_q       <= pending_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            rd_count_q      <= rd_count_d;
            underflow_err_q <= underflow_err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer-side controller for the synchronous FIFO.
- Drives the FIFO read port (rd_en), captures data_out one cycle later, and presents the words on a valid/ready output stream through a 2-entry skid buffer.
- Sustains 1 word/cycle under continuous downstream ready.
- Reports drained-word count and a sticky underflow error; sits between the FIFO and any downstream consumer/scoreboard path.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the FIFO instance.
- CNT_WIDTH, 16, width of the drained-word counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  1 = fetch from FIFO; 0 = stop issuing reads and drain what is held
- flush  in  1  1-cycle pulse: discard buffered and in-flight words, go IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag, valid in the cycle after a read
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after rd_en
- fifo_rd_en  out  1  FIFO read enable
- m_valid  out  1  output word valid
- m_data  out  FIFO_WIDTH  output word
- m_ready  in  1  downstream accept
- rd_count  out  CNT_WIDTH  words accepted downstream (m_valid & m_ready), wraps mod 2^CNT_WIDTH
- underflow_err  out  1  sticky; set on any captured underflow, cleared only by rst
- idle  out  1  1 when state is IDLE

Behaviour:
- Reset (rst=1 at an edge), all registers cleared:
  - fifo_rd_en=0, m_valid=0, m_data=0
  - rd_count=0, underflow_err=0, idle=1
  - occ=0, pending=0, state=IDLE
  - Reset mid-operation drops buffered and in-flight words.
- Internal registers:
  - occ: skid-buffer occupancy, 0..2.
  - pending: registered copy of fifo_rd_en, meaning one word is in flight.
  - Invariant: occ + pending <= 2.
- pop = m_valid & m_ready.
- m_valid = (occ != 0); m_data = buffer head. Order is strictly FIFO.
- fifo_rd_en is combinational:
  - fifo_rd_en = (state==RUN) & ~fifo_empty & ~flush & ((occ + pending) < 2 | pop).
  - Never asserted while fifo_empty=1, so the block never causes an underflow under a correct FIFO.
- Capture: when pending=1, fifo_data_out is written to the buffer tail at the next edge.
  - If fifo_underflow=1 in that cycle, the word is discarded and underflow_err is set.
- Push and pop in the same cycle: occ unchanged; head advances and the new word goes to the tail.
- Latency: rd_en in cycle T -> fifo_data_out valid in T+1 -> m_valid in T+2.
- Throughput: with m_ready held at 1, steady state is occ=1, pending=1, rd_en=1 every cycle.
- Backpressure: m_ready=0 -> occ fills to 2 and rd_en deasserts. Any in-flight word always has a free slot, so no data is lost.
- State machine:
  - IDLE: no reads.
    - enable=1 -> RUN.
  - RUN: reads issued per the rule above.
    - enable=0 -> DRAIN if occ+pending>0, else IDLE.
  - DRAIN: no new reads; in-flight word still captured; buffered words still presented.
    - occ=0 & pending=0 -> IDLE.
    - enable=1 -> RUN.
  - flush=1 in any state (highest priority after rst):
    - next state IDLE, occ=0.
    - Any word arriving from a read issued before the flush is dropped without error.
    - rd_count is kept.
- rd_count increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- The FIFO's flags must update on the same edge as the read; the reader adds no extra guard cycles.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with fifo_empty=0 and enable=0 -> fifo_rd_en=0, m_valid=0, rd_count=0, idle=1.
- Single word: FIFO holds 0xA5A5, enable=1, m_ready=1.
  - fifo_rd_en=1 at T.
  - m_valid=1 with m_data=0xA5A5 at T+2 for one cycle.
  - rd_count=1; state returns to idle after enable=0.
- Streaming: FIFO preloaded with 0x0001..0x0008, m_ready=1 -> 8 consecutive m_valid cycles, data 1..8 in order, rd_count=8, no bubbles after the first word.
- Backpressure: 8 words, m_ready=0 for cycles 3-10 then 1.
  - occ saturates at 2 and rd_en stays low while full.
  - All 8 words arrive in order; none lost or duplicated.
- Flush: flush while occ=2 and pending=1 -> m_valid=0 next cycle, idle=1, rd_count unchanged, later enable resumes from the next FIFO word.
- Underflow and wrap:
  - Force fifo_underflow=1 in a capture cycle -> that word is dropped and underflow_err=1 until rst.
  - With CNT_WIDTH=4, 17 accepted words -> rd_count=1.
